match_report_arb: RTL and testbench

Round-robin scheduler that collects match reports from REQ_NUM parallel Aho-Corasick matching engines and serializes them onto one valid/ready report stream toward the host-side report FIFO. Each engine gets a one-entry holding slot, so an engine's report is never lost while the shared output is busy. Arbitration is fair rotating priority, replacing the fixed lowest-index priority used for one-hot word selection. The block also keeps a free-running count of delivered reports for status readout.

---
 rtl/match_report_arb.sv | 114 +++++++++++
 tb/tb_match_report_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_report_arb.sv
// Round-robin collector for per-engine match reports: one holding slot per engine,
// a single registered valid/ready output stream and a delivered-report counter.
module match_report_arb #(
   parameter int REQ_NUM   = 4,
   parameter int REQ_NUM_W = (REQ_NUM == 1) ? 1 : $clog2(REQ_NUM),
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [REQ_NUM-1:0]        req_valid_i,
   input  logic [REQ_NUM*DATA_W-1:0] req_data_i,
   output logic [REQ_NUM-1:0]        req_ready_o,
   output logic                      out_valid_o,
   output logic [DATA_W-1:0]         out_data_o,
   output logic [REQ_NUM_W-1:0]      out_num_o,
   input  logic                      out_ready_i,
   output logic [CNT_W-1:0]          rpt_cnt_o
);

   logic [REQ_NUM-1:0]   hold_vld;
   logic [DATA_W-1:0]    hold_data [REQ_NUM];
   logic [REQ_NUM_W-1:0] rr_ptr;
   logic [REQ_NUM_W-1:0] rr_nxt;
   logic                 free;
   logic [REQ_NUM-1:0]   grant_vec;
   logic [REQ_NUM_W-1:0] grant_num;
   logic [DATA_W-1:0]    grant_data;
   logic [REQ_NUM-1:0]   hi_oh;
   logic [REQ_NUM-1:0]   lo_oh;
   logic                 hi_found;
   logic                 lo_found;

   assign free        = ~out_valid_o | out_ready_i;
   assign req_ready_o = ~hold_vld;

   // Rotating scan split in two: first set slot at or above rr_ptr, else first set slot below it.
   always_comb begin
      hi_oh      = '0;
      lo_oh      = '0;
      hi_found   = 1'b0;
      lo_found   = 1'b0;
      grant_vec  = '0;
      grant_num  = '0;
      grant_data = '0;
      rr_nxt     = rr_ptr;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (hold_vld[i]) begin
            if (REQ_NUM_W'(i) >= rr_ptr) begin
               if (!hi_found) begin
                  hi_found = 1'b1;
                  hi_oh[i] = 1'b1;
               end
            end else if (!lo_found) begin
               lo_found = 1'b1;
               lo_oh[i] = 1'b1;
            end
         end
      end
      if (free) begin
         grant_vec = hi_found ? hi_oh : lo_oh;
      end
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (grant_vec[i]) begin
            grant_num  = REQ_NUM_W'(i);
            grant_data = hold_data[i];
            rr_nxt     = (i == REQ_NUM - 1) ? '0 : REQ_NUM_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_vld <= '0;
         for (int unsigned i = 0; i < REQ_NUM; i++) begin
            hold_data[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (grant_vec[i]) begin
               hold_vld[i] <= 1'b0;
            end else if (req_valid_i[i] && !hold_vld[i]) begin
               hold_vld[i]  <= 1'b1;
               hold_data[i] <= req_data_i[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_num_o   <= '0;
         rr_ptr      <= '0;
      end else if (|grant_vec) begin
         out_valid_o <= 1'b1;
         out_data_o  <= grant_data;
         out_num_o   <= grant_num;
         rr_ptr      <= rr_nxt;
      end else if (free) begin
         out_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rpt_cnt_o <= '0;
      end else if (out_valid_o && out_ready_i) begin
         rpt_cnt_o <= rpt_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_match_report_arb.sv
// Directed and random checks of match_report_arb against a cycle-level slot/output model.
module tb_match_report_arb;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = 4;
   localparam int NW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [NW-1:0]   out_num;
   logic            out_ready;
   logic [CW-1:0]   rpt_cnt;

   int total = 0;
   int bad   = 0;

   bit m_pend  [N];
   int m_pdata [N];
   bit m_ov;
   int m_od, m_on, m_rr, m_cnt;

   always #5 clk = ~clk;

   match_report_arb #(.REQ_NUM(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_num_o(out_num),
      .out_ready_i(out_ready), .rpt_cnt_o(rpt_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i]  = 1'b0;
         m_pdata[i] = 0;
      end
      m_ov = 1'b0; m_od = 0; m_on = 0; m_rr = 0; m_cnt = 0;
   endtask

   // One clock edge of the arbiter as described by its transfer rules.
   task automatic model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
      bit acc [N];
      bit fr;
      int g;
      for (int i = 0; i < N; i++) acc[i] = v[i] && !m_pend[i];
      if (m_ov && r) m_cnt = (m_cnt + 1) % (1 << CW);
      fr = !m_ov || r;
      g  = -1;
      if (fr) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
      end
      if (g >= 0) begin
         m_ov = 1'b1; m_od = m_pdata[g]; m_on = g; m_pend[g] = 1'b0; m_rr = (g + 1) % N;
      end else if (fr) begin
         m_ov = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            m_pend[i]  = 1'b1;
            m_pdata[i] = int'(d[i*DW +: DW]);
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] er;
      for (int i = 0; i < N; i++) er[i] = !m_pend[i];
      chk("req_ready", req_ready, er);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_num", out_num, m_on);
      chk("rpt_cnt", rpt_cnt, m_cnt);
   endtask

   task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
      @(negedge clk);
      req_valid = v; req_data = d; out_ready = r;
      @(posedge clk);
      #1;
      model_edge(v, d, r);
      compare_all();
   endtask

   task automatic reset_chk();
      chk("rst_ready", req_ready, 4'hF);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_num", out_num, 0);
      chk("rst_cnt", rpt_cnt, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1; req_valid = '0; out_ready = 1'b0;
      #1;
      reset_chk();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int prev, n, guard, n_del;
      logic [DW-1:0] sd;
      logic [NW-1:0] sn;
      logic [CW-1:0] sc;
      logic          pre;

      rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
      #1;
      reset_chk();
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // single engine
      step(4'b0100, 64'h0000_00AA_0000_0000, 1'b1);
      chk("single_ready_low", req_ready, 4'b1011);
      chk("single_not_yet", out_valid, 0);
      step('0, '0, 1'b1);
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 16'h00AA);
      chk("single_num", out_num, 2);
      chk("single_ready_back", req_ready, 4'hF);
      step('0, '0, 1'b1);
      chk("single_cnt", rpt_cnt, 1);

      // simultaneous, then rotation wrap
      do_reset();
      step(4'hF, 64'h0013_0012_0011_0010, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step('0, '0, 1'b1);
         chk("simul_num", out_num, k);
         chk("simul_data", out_data, 16'h0010 + k);
      end
      step(4'b1001, 64'h0033_0000_0000_0030, 1'b1);
      chk("simul_cnt", rpt_cnt, 4);
      step('0, '0, 1'b1);
      chk("wrap_first", out_num, 0);
      step('0, '0, 1'b1);
      chk("wrap_second", out_num, 3);

      // continuous requests: strict rotation
      do_reset();
      prev = -1;
      for (int c = 0; c < 16; c++) begin
         step(4'hF, {$urandom(), $urandom()}, 1'b1);
         if (out_valid) begin
            if (prev >= 0) chk("rr_seq", out_num, (prev + 1) % N);
            prev = int'(out_num);
         end
      end

      // backpressure
      do_reset();
      step(4'b0010, 64'h0000_0000_00A1_0000, 1'b1);
      step('0, '0, 1'b1);
      sd = out_data; sn = out_num; sc = rpt_cnt;
      for (int c = 0; c < 5; c++) begin
         step(4'hF, {$urandom(), $urandom()}, 1'b0);
         chk("bp_data", out_data, sd);
         chk("bp_num", out_num, sn);
         chk("bp_cnt", rpt_cnt, sc);
      end
      chk("bp_ready_full", req_ready, 4'h0);
      n_del = 0; guard = 0;
      while (out_valid && guard < 20) begin
         pre = out_valid;
         step('0, '0, 1'b1);
         if (pre) n_del++;
         guard++;
      end
      chk("bp_drain_count", n_del, 5);
      chk("bp_drain_empty", out_valid, 0);
      chk("bp_drain_cnt", rpt_cnt, CW'(sc + 5));

      // reset mid-operation
      do_reset();
      step(4'b0111, 64'h0000_00C2_00C1_00C0, 1'b0);
      step('0, '0, 1'b0);
      step(4'b0001, 64'h0000_0000_0000_00C4, 1'b0);
      chk("mid_valid", out_valid, 1);
      chk("mid_slots", req_ready, 4'b1000);
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step('0, '0, 1'b1);
         chk("no_stale", out_valid, 0);
      end

      // counter wrap
      do_reset();
      n = 0; guard = 0;
      while (n < 17 && guard < 100) begin
         pre = out_valid;
         step(4'hF, {$urandom(), $urandom()}, 1'b1);
         if (pre) n++;
         guard++;
      end
      chk("wrap_deliveries", n, 17);
      chk("cnt_wrap", rpt_cnt, 1);

      // random traffic
      do_reset();
      for (int c = 0; c < 300; c++) begin
         step(N'($urandom()), {$urandom(), $urandom()}, ($urandom() % 4) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
